// File: rtl/scan_test_controller.sv
// Scan-test sequencer: shifts LFSR patterns into a scan chain, pulses capture, compresses unload into a MISR.
// Result (pass/signature) is registered on DONE entry and held until the next accepted start.
module scan_test_controller #(
  parameter int         CHAIN_LEN    = 8,
  parameter int         NUM_PATTERNS = 4,
  parameter logic [7:0] SEED         = 8'hBD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] golden,
  input  logic       scan_out,
  output logic       scan_en,
  output logic       scan_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam int             SW         = $clog2(CHAIN_LEN);
  localparam logic [SW-1:0]  SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [7:0]     PAT_LAST   = 8'(NUM_PATTERNS);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    misr_q, misr_d;
  logic [7:0]    golden_q, golden_d;
  logic [7:0]    pat_cnt_q, pat_cnt_d;
  logic [SW-1:0] shift_cnt_q, shift_cnt_d;
  logic          pass_q, pass_d;
  logic          scan_en_q, scan_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    golden_d    = golden_q;
    pat_cnt_d   = pat_cnt_q;
    shift_cnt_d = shift_cnt_q;
    pass_d      = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SHIFT;
          lfsr_d      = SEED;
          misr_d      = 8'h00;
          golden_d    = golden;
          pat_cnt_d   = 8'h00;
          shift_cnt_d = '0;
          pass_d      = 1'b0;
        end
      end
      SHIFT: begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // The first shift phase only unloads reset contents, so it is not compressed.
        if (pat_cnt_q != 8'h00)
          misr_d = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3] ^ scan_out};
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          if (pat_cnt_q == PAT_LAST) begin
            state_d = DONE;
            pass_d  = (misr_d == golden_q);
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        state_d     = SHIFT;
        pat_cnt_d   = pat_cnt_q + 8'h01;
        shift_cnt_d = '0;
      end
    endcase

    // Abort overrides every busy-state transition and freezes the MISR where it stands.
    if (abort && (state_q == SHIFT || state_q == CAPTURE)) begin
      state_d     = IDLE;
      lfsr_d      = lfsr_q;
      misr_d      = misr_q;
      pat_cnt_d   = 8'h00;
      shift_cnt_d = '0;
      pass_d      = 1'b0;
    end

    scan_en_d = (state_d == SHIFT);
    busy_d    = (state_d == SHIFT) || (state_d == CAPTURE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      misr_q      <= 8'h00;
      golden_q    <= 8'h00;
      pat_cnt_q   <= 8'h00;
      shift_cnt_q <= '0;
      pass_q      <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      golden_q    <= golden_d;
      pat_cnt_q   <= pat_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      pass_q      <= pass_d;
      scan_en_q   <= scan_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign scan_en   = scan_en_q;
  assign scan_in   = lfsr_q[7];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule
